wb_stage: RTL

Writeback stage of the five-stage LoongArch pipeline, directly upstream of the CSR file. It latches the instruction leaving MEM and commits its side effects:

- GPR write-back and debug trace.
- CSR read/write and counter reads (rdcnt*).
- Exception commit: prioritises pending exception flags, drives the CSR file's exception/ERTN inputs, and broadcasts a pipeline flush.

---
 rtl/wb_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: latches the instruction leaving MEM, commits GPR/CSR side effects,
// prioritises exceptions for the CSR file and raises the pipeline flush.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  input  logic [31:0] ms_vaddr,
  input  logic [5:0]  ms_ex,
  input  logic        ms_ertn,
  input  logic        ms_csr_re,
  input  logic        ms_csr_we,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wmask,
  input  logic [31:0] ms_csr_wvalue,
  input  logic [1:0]  ms_cnt_sel,
  input  logic [31:0] csr_rvalue,
  input  logic [63:0] count,
  input  logic [31:0] tid,
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  output logic        ws_flush,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_fwd_valid,
  output logic        ws_csr_hazard,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic        ws_valid_q;
  logic [31:0] ws_pc_q;
  logic        ws_gr_we_q;
  logic [4:0]  ws_dest_q;
  logic [31:0] ws_result_q;
  logic [31:0] ws_vaddr_q;
  logic [5:0]  ws_ex_q;
  logic        ws_ertn_q;
  logic        ws_csr_re_q;
  logic        ws_csr_we_q;
  logic [13:0] ws_csr_num_q;
  logic [31:0] ws_csr_wmask_q;
  logic [31:0] ws_csr_wvalue_q;
  logic [1:0]  ws_cnt_sel_q;

  logic        ws_ready_go;
  logic        ws_valid_d;
  logic [5:0]  ecode_d;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = ~ws_valid_q | ws_ready_go;
  // An instruction offered while WB is flushing belongs to the killed path.
  assign ws_valid_d  = ms_to_ws_valid & ~ws_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_valid_q      <= 1'b0;
      ws_pc_q         <= 32'd0;
      ws_gr_we_q      <= 1'b0;
      ws_dest_q       <= 5'd0;
      ws_result_q     <= 32'd0;
      ws_vaddr_q      <= 32'd0;
      ws_ex_q         <= 6'd0;
      ws_ertn_q       <= 1'b0;
      ws_csr_re_q     <= 1'b0;
      ws_csr_we_q     <= 1'b0;
      ws_csr_num_q    <= 14'd0;
      ws_csr_wmask_q  <= 32'd0;
      ws_csr_wvalue_q <= 32'd0;
      ws_cnt_sel_q    <= 2'd0;
    end else if (ws_allowin) begin
      ws_valid_q      <= ws_valid_d;
      ws_pc_q         <= ms_pc;
      ws_gr_we_q      <= ms_gr_we;
      ws_dest_q       <= ms_dest;
      ws_result_q     <= ms_result;
      ws_vaddr_q      <= ms_vaddr;
      ws_ex_q         <= ms_ex;
      ws_ertn_q       <= ms_ertn;
      ws_csr_re_q     <= ms_csr_re;
      ws_csr_we_q     <= ms_csr_we;
      ws_csr_num_q    <= ms_csr_num;
      ws_csr_wmask_q  <= ms_csr_wmask;
      ws_csr_wvalue_q <= ms_csr_wvalue;
      ws_cnt_sel_q    <= ms_cnt_sel;
    end
  end

  // Flag order is {int, adef, ine, sys, brk, ale}; the highest set flag wins.
  always_comb begin
    ecode_d = 6'h00;
    if (ws_valid_q) begin
      if      (ws_ex_q[5]) ecode_d = 6'h00;
      else if (ws_ex_q[4]) ecode_d = 6'h08;
      else if (ws_ex_q[3]) ecode_d = 6'h0D;
      else if (ws_ex_q[2]) ecode_d = 6'h0B;
      else if (ws_ex_q[1]) ecode_d = 6'h0C;
      else if (ws_ex_q[0]) ecode_d = 6'h09;
    end
  end

  assign wb_ex       = ws_valid_q & (|ws_ex_q);
  assign wb_ecode    = ecode_d;
  assign wb_esubcode = 9'd0;
  assign wb_pc       = ws_pc_q;
  assign wb_vaddr    = ws_vaddr_q;
  assign ertn_flush  = ws_valid_q & ws_ertn_q & ~(|ws_ex_q);
  assign ws_flush    = wb_ex | ertn_flush;

  assign csr_re     = ws_valid_q & ws_csr_re_q;
  assign csr_we     = ws_valid_q & ws_csr_we_q & ~wb_ex;
  assign csr_num    = ws_csr_num_q;
  assign csr_wmask  = ws_csr_wmask_q;
  assign csr_wvalue = ws_csr_wvalue_q;

  always_comb begin
    rf_wdata = ws_result_q;
    if (ws_csr_re_q) begin
      rf_wdata = csr_rvalue;
    end else begin
      case (ws_cnt_sel_q)
        2'b01:   rf_wdata = count[31:0];
        2'b10:   rf_wdata = count[63:32];
        2'b11:   rf_wdata = tid;
        default: rf_wdata = ws_result_q;
      endcase
    end
  end

  assign rf_we         = ws_valid_q & ws_gr_we_q & ~wb_ex;
  assign rf_waddr      = ws_dest_q;
  assign ws_fwd_valid  = ws_valid_q & rf_we;
  assign ws_csr_hazard = ws_valid_q & (ws_csr_we_q | ws_ertn_q | (|ws_ex_q));

  assign debug_wb_pc       = ws_pc_q;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule
